// File: rtl/object_move_gen.sv
// Purpose : fixed-point trajectory generator for one on-screen object, one step per video frame.
// Latency : startOfFrame at cycle t -> raw new position at t+2, edge-limited position at t+3.
// Backpr. : none; inputs are sampled every cycle and outputs are always valid.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset (overrides everything)
//   startOfFrame        - one-cycle pulse per video frame
//   enable              - 0 freezes motion (frames are skipped)
//   jump_key            - rising edge sets an upward speed of JUMP_SPEED
//   toggle_x_key        - rising edge negates the X speed
//   collision           - object hit something; HitEdgeCode says which side [3]=L [2]=T [1]=R [0]=B
//   load, load_x/load_y - force the pixel position (ignored while idle)
//   topLeftX/topLeftY   - integer pixel position (floor of the fixed-point position)
//   edge_hit            - one-cycle pulse per screen edge reached, same bit order as HitEdgeCode
module object_move_gen #(
  parameter int FP_SHIFT        = 6,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 64,
  parameter int SAFETY_MARGIN   = 2,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 20,
  parameter int Y_ACCEL         = 5,
  parameter int JUMP_SPEED      = 300,
  parameter int MAX_X_SPEED     = 400,
  parameter int MAX_Y_SPEED     = 400,
  parameter int EDGE_MODE       = 0    // 0=bounce, 1=wrap, 2=stop
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               jump_key,
  input  logic               toggle_x_key,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  input  logic               load,
  input  logic signed [10:0] load_x,
  input  logic signed [10:0] load_y,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [3:0]         edge_hit
);

  localparam logic signed [31:0] X_L      = 32'(SAFETY_MARGIN << FP_SHIFT);
  localparam logic signed [31:0] X_R      = 32'((FRAME_WIDTH - 1 - SAFETY_MARGIN - OBJECT_WIDTH_X) << FP_SHIFT);
  localparam logic signed [31:0] Y_T      = 32'(SAFETY_MARGIN << FP_SHIFT);
  localparam logic signed [31:0] Y_B      = 32'((FRAME_HEIGHT - 1 - SAFETY_MARGIN - OBJECT_HEIGHT_Y) << FP_SHIFT);
  localparam logic signed [31:0] X_INIT   = 32'(INITIAL_X << FP_SHIFT);
  localparam logic signed [31:0] Y_INIT   = 32'(INITIAL_Y << FP_SHIFT);
  localparam logic signed [31:0] VX_INIT  = 32'(INITIAL_X_SPEED);
  localparam logic signed [31:0] VY_INIT  = 32'(INITIAL_Y_SPEED);
  localparam logic signed [31:0] Y_ACC    = 32'(Y_ACCEL);
  localparam logic signed [31:0] JUMP_VEL = 32'(-JUMP_SPEED);
  localparam logic signed [31:0] VX_MAX   = 32'(MAX_X_SPEED);
  localparam logic signed [31:0] VY_MAX   = 32'(MAX_Y_SPEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_WAIT_EOF,
    S_POS_CHANGE,
    S_LIMITS
  } state_t;

  typedef struct packed {
    logic signed [31:0] pos;
    logic signed [31:0] spd;
  } axis_t;

  state_t             state_q, state_d;
  logic signed [31:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic signed [31:0] xspd_q, xspd_d, yspd_q, yspd_d;
  logic [3:0]         edge_hit_q, edge_hit_d;
  logic               jump_dly_q, jump_dly_d;
  logic               tog_dly_q, tog_dly_d;

  logic  jump_edge, tog_edge;
  logic  x_lo, x_hi, y_lo, y_hi;
  axis_t x_lim, y_lim;

  function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                             input logic signed [31:0] lim);
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

  // Edge handling for one axis. "Exactly on a limit" is in range.
  function automatic axis_t limit_axis(input logic signed [31:0] pos,
                                       input logic signed [31:0] spd,
                                       input logic signed [31:0] lo,
                                       input logic signed [31:0] hi);
    axis_t r;
    r.pos = pos;
    r.spd = spd;
    if (pos < lo) begin
      if (EDGE_MODE == 1) begin
        r.pos = hi;
      end else begin
        r.pos = lo;
        if (EDGE_MODE == 2)  r.spd = '0;
        else if (spd < 0)    r.spd = -spd;   // reflect only outward-pointing speed
      end
    end else if (pos > hi) begin
      if (EDGE_MODE == 1) begin
        r.pos = lo;
      end else begin
        r.pos = hi;
        if (EDGE_MODE == 2)  r.spd = '0;
        else if (spd > 0)    r.spd = -spd;
      end
    end
    return r;
  endfunction

  assign jump_edge = jump_key & ~jump_dly_q;
  assign tog_edge  = toggle_x_key & ~tog_dly_q;

  assign x_lo = xpos_q < X_L;
  assign x_hi = xpos_q > X_R;
  assign y_lo = ypos_q < Y_T;
  assign y_hi = ypos_q > Y_B;

  assign x_lim = limit_axis(xpos_q, xspd_q, X_L, X_R);
  assign y_lim = limit_axis(ypos_q, yspd_q, Y_T, Y_B);

  always_comb begin
    state_d    = state_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    xspd_d     = xspd_q;
    yspd_d     = yspd_q;
    edge_hit_d = '0;
    jump_dly_d = jump_key;
    tog_dly_d  = toggle_x_key;

    case (state_q)
      S_IDLE: begin
        if (startOfFrame) state_d = S_MOVE;
      end

      S_MOVE, S_WAIT_EOF: begin
        if (tog_edge)  xspd_d = -xspd_q;
        if (jump_edge) yspd_d = JUMP_VEL;
        // Collision acts on the post-key speeds; only the first one per frame counts.
        if (state_q == S_MOVE && collision) begin
          if (HitEdgeCode[3] && xspd_d < 0) xspd_d = -xspd_d;
          if (HitEdgeCode[1] && xspd_d > 0) xspd_d = -xspd_d;
          if (HitEdgeCode[2] && yspd_d < 0) yspd_d = -yspd_d;
          if (HitEdgeCode[0] && yspd_d > 0) yspd_d = -yspd_d;
          state_d = S_WAIT_EOF;
        end
        if (startOfFrame && enable) state_d = S_POS_CHANGE;
      end

      S_POS_CHANGE: begin
        xpos_d  = xpos_q + xspd_q;
        ypos_d  = ypos_q + yspd_q;
        yspd_d  = sat(yspd_q + Y_ACC, VY_MAX);
        xspd_d  = sat(xspd_q, VX_MAX);
        state_d = S_LIMITS;
      end

      S_LIMITS: begin
        xpos_d     = x_lim.pos;
        xspd_d     = x_lim.spd;
        ypos_d     = y_lim.pos;
        yspd_d     = y_lim.spd;
        edge_hit_d = {x_lo, y_lo, x_hi, y_hi};
        state_d    = S_MOVE;
      end

      default: state_d = S_IDLE;
    endcase

    // Load overrides any position write but leaves speeds and state flow alone.
    if (load && state_q != S_IDLE) begin
      xpos_d = {{21{load_x[10]}}, load_x} << FP_SHIFT;
      ypos_d = {{21{load_y[10]}}, load_y} << FP_SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      xpos_q     <= X_INIT;
      ypos_q     <= Y_INIT;
      xspd_q     <= VX_INIT;
      yspd_q     <= VY_INIT;
      edge_hit_q <= '0;
      jump_dly_q <= 1'b0;
      tog_dly_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      xspd_q     <= xspd_d;
      yspd_q     <= yspd_d;
      edge_hit_q <= edge_hit_d;
      jump_dly_q <= jump_dly_d;
      tog_dly_q  <= tog_dly_d;
    end
  end

  assign topLeftX = 11'(xpos_q >>> FP_SHIFT);
  assign topLeftY = 11'(ypos_q >>> FP_SHIFT);
  assign edge_hit = edge_hit_q;

endmodule

// File: tb/tb_object_move_gen.sv
// Bench for object_move_gen: four instances (default bounce, bottom bounce, wrap, stop)
// share one stimulus stream; each is compared every cycle against a frame-level model.
module tb_object_move_gen;

  localparam int NDUT = 4;
  localparam int FP   = 6;
  localparam int XL   = 2 * 64;
  localparam int XR   = (640 - 1 - 2 - 64) * 64;
  localparam int YT   = 2 * 64;
  localparam int YB   = (480 - 1 - 2 - 64) * 64;
  localparam int ACC  = 5;
  localparam int JMP  = 300;
  localparam int VMAX = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sof = 1'b0, enable = 1'b1, jump_key = 1'b0, toggle_x_key = 1'b0, collision = 1'b0;
  logic [3:0] hit_code = 4'b0000;
  logic load = 1'b0;
  logic signed [10:0] load_x = '0, load_y = '0;

  logic signed [10:0] o_x [NDUT];
  logic signed [10:0] o_y [NDUT];
  logic [3:0]         o_eh [NDUT];
  logic signed [31:0] px [NDUT];
  logic signed [31:0] py [NDUT];
  logic signed [31:0] sx [NDUT];
  logic signed [31:0] sy [NDUT];

  always #5 clk = ~clk;

  object_move_gen u_dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .jump_key(jump_key),
    .toggle_x_key(toggle_x_key), .collision(collision), .HitEdgeCode(hit_code), .load(load),
    .load_x(load_x), .load_y(load_y), .topLeftX(o_x[0]), .topLeftY(o_y[0]), .edge_hit(o_eh[0]));

  object_move_gen #(.INITIAL_Y(412), .INITIAL_Y_SPEED(128)) u_dut1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .jump_key(jump_key),
    .toggle_x_key(toggle_x_key), .collision(collision), .HitEdgeCode(hit_code), .load(load),
    .load_x(load_x), .load_y(load_y), .topLeftX(o_x[1]), .topLeftY(o_y[1]), .edge_hit(o_eh[1]));

  object_move_gen #(.EDGE_MODE(1), .INITIAL_X(573), .INITIAL_X_SPEED(64)) u_dut2 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .jump_key(jump_key),
    .toggle_x_key(toggle_x_key), .collision(collision), .HitEdgeCode(hit_code), .load(load),
    .load_x(load_x), .load_y(load_y), .topLeftX(o_x[2]), .topLeftY(o_y[2]), .edge_hit(o_eh[2]));

  object_move_gen #(.EDGE_MODE(2), .INITIAL_X(2), .INITIAL_X_SPEED(-40)) u_dut3 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .enable(enable), .jump_key(jump_key),
    .toggle_x_key(toggle_x_key), .collision(collision), .HitEdgeCode(hit_code), .load(load),
    .load_x(load_x), .load_y(load_y), .topLeftX(o_x[3]), .topLeftY(o_y[3]), .edge_hit(o_eh[3]));

  assign px[0] = u_dut0.xpos_q;  assign py[0] = u_dut0.ypos_q;
  assign sx[0] = u_dut0.xspd_q;  assign sy[0] = u_dut0.yspd_q;
  assign px[1] = u_dut1.xpos_q;  assign py[1] = u_dut1.ypos_q;
  assign sx[1] = u_dut1.xspd_q;  assign sy[1] = u_dut1.yspd_q;
  assign px[2] = u_dut2.xpos_q;  assign py[2] = u_dut2.ypos_q;
  assign sx[2] = u_dut2.xspd_q;  assign sy[2] = u_dut2.yspd_q;
  assign px[3] = u_dut3.xpos_q;  assign py[3] = u_dut3.ypos_q;
  assign sx[3] = u_dut3.xspd_q;  assign sy[3] = u_dut3.yspd_q;

  // Per-instance start values and edge mode.
  int p_ix [NDUT] = '{280, 280, 573, 2};
  int p_iy [NDUT] = '{185, 412, 185, 185};
  int p_ivx[NDUT] = '{40, 40, 64, -40};
  int p_ivy[NDUT] = '{20, 128, 20, 20};
  int p_mode[NDUT] = '{0, 0, 1, 2};

  // Model: running = started by a first frame pulse; pend counts the two
  // frame-update cycles still owed (2 = move, 1 = edge handling).
  int   mx[NDUT], my[NDUT], mvx[NDUT], mvy[NDUT], mpend[NDUT];
  bit   mrun[NDUT], mlock[NDUT];
  logic [3:0] mhit[NDUT];
  bit   jd, td;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int m);
    if (v > m)  return m;
    if (v < -m) return -m;
    return v;
  endfunction

  task automatic lim(input int mode, input int lo, input int hi, input int p_in, input int v_in,
                     output int p, output int v, output bit hlo, output bit hhi);
    p = p_in; v = v_in;
    hlo = p_in < lo;
    hhi = p_in > hi;
    if (hlo || hhi) begin
      case (mode)
        1: p = hlo ? hi : lo;
        2: begin p = hlo ? lo : hi; v = 0; end
        default: begin
          p = hlo ? lo : hi;
          if ((hlo && v_in < 0) || (hhi && v_in > 0)) v = -v_in;
        end
      endcase
    end
  endtask

  task automatic model_step(input int i);
    bit je, te, was_run, xl, xh, yl, yh;
    int np, nv;
    if (reset) begin
      mx[i] = p_ix[i] * 64;  my[i] = p_iy[i] * 64;
      mvx[i] = p_ivx[i];     mvy[i] = p_ivy[i];
      mpend[i] = 0; mrun[i] = 0; mlock[i] = 0; mhit[i] = 4'b0000;
      return;
    end
    je = jump_key && !jd;
    te = toggle_x_key && !td;
    mhit[i] = 4'b0000;
    was_run = mrun[i];
    if (!mrun[i]) begin
      if (sof) mrun[i] = 1;
    end else if (mpend[i] == 2) begin
      mx[i] = mx[i] + mvx[i];
      my[i] = my[i] + mvy[i];
      mvy[i] = clip(mvy[i] + ACC, VMAX);
      mvx[i] = clip(mvx[i], VMAX);
      mpend[i] = 1;
    end else if (mpend[i] == 1) begin
      lim(p_mode[i], XL, XR, mx[i], mvx[i], np, nv, xl, xh);
      mx[i] = np; mvx[i] = nv;
      lim(p_mode[i], YT, YB, my[i], mvy[i], np, nv, yl, yh);
      my[i] = np; mvy[i] = nv;
      mhit[i] = {xl, yl, xh, yh};
      mpend[i] = 0;
      mlock[i] = 0;
    end else begin
      if (te) mvx[i] = -mvx[i];
      if (je) mvy[i] = -JMP;
      if (collision && !mlock[i]) begin
        if (hit_code[3] && mvx[i] < 0) mvx[i] = -mvx[i];
        if (hit_code[1] && mvx[i] > 0) mvx[i] = -mvx[i];
        if (hit_code[2] && mvy[i] < 0) mvy[i] = -mvy[i];
        if (hit_code[0] && mvy[i] > 0) mvy[i] = -mvy[i];
        mlock[i] = 1;
      end
      if (sof && enable) mpend[i] = 2;
    end
    if (was_run && load) begin
      mx[i] = int'(load_x) * 64;
      my[i] = int'(load_y) * 64;
    end
  endtask

  task automatic tick();
    logic signed [10:0] ex, ey;
    for (int i = 0; i < NDUT; i++) model_step(i);
    jd = reset ? 1'b0 : jump_key;
    td = reset ? 1'b0 : toggle_x_key;
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      ex = 11'(mx[i] >>> FP);
      ey = 11'(my[i] >>> FP);
      check($sformatf("dut%0d.topLeftX", i), o_x[i], ex);
      check($sformatf("dut%0d.topLeftY", i), o_y[i], ey);
      check($sformatf("dut%0d.edge_hit", i), o_eh[i], mhit[i]);
      check($sformatf("dut%0d.Xpos", i), px[i], mx[i]);
      check($sformatf("dut%0d.Ypos", i), py[i], my[i]);
      check($sformatf("dut%0d.Xspd", i), sx[i], mvx[i]);
      check($sformatf("dut%0d.Yspd", i), sy[i], mvy[i]);
    end
  endtask

  task automatic frame();
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    int saved_x, saved_y, gap;

    // Reset
    reset = 1'b1;
    repeat (3) tick();
    check("rst_topLeftX", o_x[0], 280);
    check("rst_topLeftY", o_y[0], 185);
    reset = 1'b0;
    repeat (2) tick();

    // First frame pulse only arms the generator
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (3) tick();
    check("arm_topLeftX", o_x[0], 280);
    check("arm_Xpos", px[0], 17920);

    // Second frame pulse: move, then edge handling
    sof = 1'b1; tick(); sof = 1'b0;
    tick();
    check("f1_Xpos", px[0], 17960);
    check("f1_Ypos", py[0], 11860);
    check("f1_Yspd", sy[0], 25);
    check("f1_topLeftX", o_x[0], 280);
    check("bot_raw_Ypos", py[1], 26496);
    tick();
    check("bot_Ypos", py[1], 26432);
    check("bot_topLeftY", o_y[1], 413);
    check("bot_Yspd", sy[1], -133);
    check("bot_edge_hit", o_eh[1], 4'b0001);
    check("wrap_topLeftX", o_x[2], 2);
    check("wrap_Xspd", sx[2], 64);
    check("wrap_edge_hit", o_eh[2], 4'b0010);
    check("stop_topLeftX", o_x[3], 2);
    check("stop_Xspd", sx[3], 0);
    check("stop_edge_hit", o_eh[3], 4'b1000);
    check("def_edge_hit", o_eh[0], 4'b0000);
    tick();
    check("bot_edge_hit_end", o_eh[1], 4'b0000);
    repeat (3) tick();

    frame();
    frame();
    check("f3_topLeftX", o_x[0], 281);
    check("stop_hold_Xpos", px[3], 128);

    // Collision on the right, then a second one in the same frame
    collision = 1'b1; hit_code = 4'b0010; tick(); collision = 1'b0;
    check("coll1_Xspd", sx[0], -40);
    tick();
    collision = 1'b1; tick(); collision = 1'b0;
    check("coll2_Xspd", sx[0], -40);
    hit_code = 4'b0000;
    frame();

    // Jump key held for three cycles: one jump
    jump_key = 1'b1; repeat (3) tick(); jump_key = 1'b0;
    check("jump_Yspd", sy[0], -300);
    tick();
    frame();

    // Pause for five frames
    enable = 1'b0;
    saved_x = mx[0]; saved_y = my[0];
    repeat (5) frame();
    check("pause_Xpos", px[0], saved_x);
    check("pause_Ypos", py[0], saved_y);
    enable = 1'b1;

    // Position load
    load = 1'b1; load_x = 11'sd100; load_y = 11'sd50; tick(); load = 1'b0;
    check("load_topLeftX", o_x[0], 100);
    check("load_topLeftY", o_y[0], 50);
    tick();

    // Reset while in the move cycle
    sof = 1'b1; tick(); sof = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("mrst_topLeftX", o_x[0], 280);
    check("mrst_topLeftY", o_y[0], 185);
    check("mrst_Xspd", sx[0], 40);
    check("mrst_Yspd", sy[0], 20);
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (3) tick();
    check("mrst_idle_Xpos", px[0], 17920);

    // Randomised traffic
    gap = 3;
    for (int n = 0; n < 2500; n++) begin
      if (gap == 0) begin
        sof = 1'b1;
        gap = $urandom_range(14, 5);
      end else begin
        sof = 1'b0;
        gap--;
      end
      enable       = ($urandom_range(7, 0) != 0);
      if ($urandom_range(9, 0) == 0) jump_key = ~jump_key;
      if ($urandom_range(9, 0) == 0) toggle_x_key = ~toggle_x_key;
      collision    = ($urandom_range(11, 0) == 0);
      hit_code     = 4'($urandom);
      load         = ($urandom_range(149, 0) == 0);
      load_x       = 11'($urandom);
      load_y       = 11'($urandom);
      reset        = ($urandom_range(399, 0) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
